av_arbiter: RTL and testbench

AV_ARBITER -- requirements
Module: av_arbiter

---
 rtl/av_arb_pkg.sv | 22 ++
 rtl/av_watchdog.sv | 34 +++
 rtl/av_arbiter.sv | 153 +++++++++++++++
 tb/tb_av_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/av_arb_pkg.sv
// Shared types and helpers for the two-port Avalon arbiter.
package av_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Read data returned to a requester whose read timed out; replicated to
  // DATA_W at the point of use so it is all-ones for any width.
  localparam logic ERR_RDATA_BIT = 1'b1;

  // Round-robin pick between the two ports: on a tie the port that did not
  // win last time gets it; otherwise the lone requester wins.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last_grant);
    if (req0 && req1) return ~last_grant;
    return req1;
  endfunction

endpackage

// File: rtl/av_watchdog.sv
// Stall watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches TIMEOUT.
module av_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear has priority; the counter is allowed past TIMEOUT since the
  // owner always clears it before the next transaction.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + CW'(1);
  end

  // Expiry is flagged on the TIMEOUT-th enabled cycle itself.
  assign expired = enable && !clear && (cnt_q == CW'(TIMEOUT - 1));

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/av_arbiter.sv
// Two-port Avalon-MM arbiter: MCU (port 0) and DMA (port 1) share one
// master. Round-robin on ties, one transaction at a time, registered master
// side, with a stall watchdog that aborts a hung fabric access.
module av_arbiter
  import av_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              sysclk,
  input  logic              sysreset_n,
  input  logic [ADDR_W-1:0] s0_address,
  input  logic              s0_read,
  input  logic              s0_write,
  input  logic [DATA_W-1:0] s0_writedata,
  output logic [DATA_W-1:0] s0_readdata,
  output logic              s0_waitrequest,
  input  logic [ADDR_W-1:0] s1_address,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_waitrequest,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_writedata,
  output logic              m_read,
  output logic              m_write,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_waitrequest,
  output logic              err,
  input  logic              err_clear,
  output logic              grant_id
);

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic                     rd_q, rd_d, wr_q, wr_d;
  logic [1:0][DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]               wait_q, wait_d;
  logic                     err_q, err_d;
  logic                     grant_q, grant_d;
  logic                     last_q, last_d;
  logic                     req0, req1, win;
  logic                     wd_clear, wd_en, wd_exp;

  assign req0 = s0_read | s0_write;
  assign req1 = s1_read | s1_write;
  assign win  = rr_pick(req0, req1, last_q);

  av_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (sysclk),
    .rst_n  (sysreset_n),
    .clear  (wd_clear),
    .enable (wd_en),
    .expired(wd_exp)
  );

  // Next-state logic: arbitrate in IDLE, run the master access in XFER,
  // ack the owner for one cycle in DONE.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    rdata_d  = rdata_q;
    wait_d   = wait_q;
    grant_d  = grant_q;
    last_d   = last_q;
    wd_clear = 1'b0;
    wd_en    = 1'b0;
    // Clear first so a timeout in the same cycle re-sets the flag.
    err_d    = err_clear ? 1'b0 : err_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          grant_d  = win;
          addr_d   = win ? s1_address   : s0_address;
          wdata_d  = win ? s1_writedata : s0_writedata;
          // Write wins when a port raises both strobes.
          wr_d     = win ? s1_write : s0_write;
          rd_d     = ~wr_d;
          wd_clear = 1'b1;
          state_d  = ST_XFER;
        end
      end
      ST_XFER: begin
        wd_en = m_waitrequest;
        if (!m_waitrequest) begin
          if (rd_q) rdata_d[grant_q] = m_readdata;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          wait_d[grant_q] = 1'b0;
          state_d = ST_DONE;
        end else if (wd_exp) begin
          if (rd_q) rdata_d[grant_q] = {DATA_W{ERR_RDATA_BIT}};
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          wait_d[grant_q] = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        wait_d  = 2'b11;
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      wait_q  <= 2'b11;
      err_q   <= 1'b0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign m_address      = addr_q;
  assign m_writedata    = wdata_q;
  assign m_read         = rd_q;
  assign m_write        = wr_q;
  assign s0_readdata    = rdata_q[0];
  assign s1_readdata    = rdata_q[1];
  assign s0_waitrequest = wait_q[0];
  assign s1_waitrequest = wait_q[1];
  assign err            = err_q;
  assign grant_id       = grant_q;

endmodule

// File: tb/tb_av_arbiter.sv
// Randomized bench for av_arbiter: a transaction-level model predicts, per
// cycle, the master strobes, ack timing, read data and error flag.
module tb_av_arbiter;
  localparam int AW = 32, DW = 16, TO = 4, NCYC = 3000;

  logic          sysclk = 1'b0, sysreset_n = 1'b0;
  logic [AW-1:0] s0_address = '0, s1_address = '0, m_address;
  logic          s0_read = 0, s0_write = 0, s1_read = 0, s1_write = 0;
  logic [DW-1:0] s0_writedata = '0, s1_writedata = '0, s0_readdata, s1_readdata;
  logic          s0_waitrequest, s1_waitrequest;
  logic [DW-1:0] m_writedata, m_readdata = '0;
  logic          m_read, m_write, m_waitrequest = 1'b1;
  logic          err, err_clear = 1'b0, grant_id;

  always #5 sysclk = ~sysclk;

  av_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .sysclk(sysclk), .sysreset_n(sysreset_n),
    .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
    .s0_writedata(s0_writedata), .s0_readdata(s0_readdata),
    .s0_waitrequest(s0_waitrequest),
    .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
    .s1_writedata(s1_writedata), .s1_readdata(s1_readdata),
    .s1_waitrequest(s1_waitrequest),
    .m_address(m_address), .m_writedata(m_writedata), .m_read(m_read),
    .m_write(m_write), .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
    .err(err), .err_clear(err_clear), .grant_id(grant_id)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Requester state: pending request, its op/addr/data, and whether a
  // transaction from that port is still awaiting its ack.
  bit            req_v[2], req_rd[2], req_wr[2], outst[2];
  logic [AW-1:0] req_a[2];
  logic [DW-1:0] req_d[2];

  // Current transaction: starts in IDLE cycle n0, strobes in n0+1..n0+len,
  // ack in n0+len+1.
  bit            busy, op_wr, tmo;
  int            n0, len, stall, win, last;
  logic [DW-1:0] fab_d;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, exp_rd[2];
  bit            exp_err, exp_grant;

  task automatic model_reset();
    busy = 0; last = 1; win = 0; len = 0; n0 = 0;
    exp_addr = '0; exp_wdata = '0; exp_rd[0] = '0; exp_rd[1] = '0;
    exp_err = 0; exp_grant = 0;
    for (int p = 0; p < 2; p++) begin req_v[p] = 0; outst[p] = 0; end
  endtask

  task automatic new_req(input int p, input int kind);
    req_v[p] = 1;
    req_rd[p] = (kind != 1);   // 0 read, 1 write, 2 both
    req_wr[p] = (kind != 0);
    req_a[p]  = $urandom;
    req_d[p]  = DW'($urandom);
  endtask

  task automatic drive_ports();
    s0_read  = req_v[0] & req_rd[0];  s0_write = req_v[0] & req_wr[0];
    s1_read  = req_v[1] & req_rd[1];  s1_write = req_v[1] & req_wr[1];
    s0_address = req_a[0]; s0_writedata = req_d[0];
    s1_address = req_a[1]; s1_writedata = req_d[1];
  endtask

  task automatic check_outputs(input string pfx, input int k);
    bit strb, ack;
    strb = busy && k >= 1 && k <= len;
    ack  = busy && k == len + 1;
    chk({pfx, "m_read"},  64'(m_read),  64'(strb && !op_wr));
    chk({pfx, "m_write"}, 64'(m_write), 64'(strb && op_wr));
    chk({pfx, "m_address"},   64'(m_address),   64'(exp_addr));
    chk({pfx, "m_writedata"}, 64'(m_writedata), 64'(exp_wdata));
    chk({pfx, "s0_waitrequest"}, 64'(s0_waitrequest), 64'(!(ack && win == 0)));
    chk({pfx, "s1_waitrequest"}, 64'(s1_waitrequest), 64'(!(ack && win == 1)));
    chk({pfx, "grant_id"},    64'(grant_id),    64'(exp_grant));
    chk({pfx, "err"},         64'(err),         64'(exp_err));
    chk({pfx, "s0_readdata"}, 64'(s0_readdata), 64'(exp_rd[0]));
    chk({pfx, "s1_readdata"}, 64'(s1_readdata), 64'(exp_rd[1]));
  endtask

  initial begin
    bit rst_done, strobe, ack, clr, tmo_now;
    int k;
    rst_done = 0;
    model_reset();
    for (int p = 0; p < 2; p++) begin
      req_rd[p] = 0; req_wr[p] = 0; req_a[p] = '0; req_d[p] = '0;
    end
    repeat (2) @(negedge sysclk);
    check_outputs("reset_", -1);
    sysreset_n = 1'b1;

    for (int c = 0; c < NCYC; c++) begin
      k = busy ? c - n0 : -1;
      check_outputs("", k);

      // One asynchronous reset in the first strobe cycle of a transaction.
      if (!rst_done && c > NCYC / 2 && busy && k == 1) begin
        rst_done = 1;
        sysreset_n = 1'b0;
        #1;
        model_reset();
        drive_ports();
        check_outputs("midrst_", -1);
        @(negedge sysclk);
        check_outputs("inrst_", -1);
        sysreset_n = 1'b1;
        k = -1;
      end

      ack    = busy && k == len + 1;
      strobe = busy && k >= 1 && k <= len;

      if (ack) begin req_v[win] = 0; outst[win] = 0; end
      // A requester may give up early; the transaction still completes.
      if (strobe && req_v[win] && $urandom_range(0, 15) == 0) req_v[win] = 0;

      if (c == 0) begin
        new_req(0, 1); new_req(1, 1);   // simultaneous writes out of reset
      end else begin
        for (int p = 0; p < 2; p++)
          if (!req_v[p] && !outst[p] && !(ack && p == win) && $urandom_range(0, 3) == 0)
            new_req(p, int'($urandom_range(0, 2)));
      end

      if (!busy && (req_v[0] || req_v[1])) begin
        win   = (req_v[0] && req_v[1]) ? 1 - last : (req_v[1] ? 1 : 0);
        last  = win;
        outst[win] = 1;
        busy  = 1;
        n0    = c;
        op_wr = req_wr[win];
        exp_addr  = req_a[win];
        exp_wdata = req_d[win];
        exp_grant = (win == 1);
        stall = int'($urandom_range(0, 7));
        tmo   = stall >= TO;
        len   = tmo ? TO : stall + 1;
        fab_d = DW'($urandom);
      end

      tmo_now = strobe && k == len && tmo;
      if (strobe) begin
        m_waitrequest = (k - 1 < stall);
        m_readdata    = fab_d;
        if (k == len && !op_wr) exp_rd[win] = tmo ? '1 : fab_d;
      end else begin
        m_waitrequest = 1'($urandom);
        m_readdata    = DW'($urandom);
      end

      clr       = ($urandom_range(0, 15) == 0);
      err_clear = clr;
      exp_err   = tmo_now ? 1'b1 : (clr ? 1'b0 : exp_err);

      if (ack) busy = 0;
      drive_ports();
      @(negedge sysclk);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
